checkpoint_queue: RTL and testbench

CHECKPOINT_QUEUE -- requirements
Module: checkpoint_queue

---
 rtl/checkpoint_queue_if.sv | 50 +++++
 rtl/checkpoint_queue.sv | 123 ++++++++++++
 tb/tb_checkpoint_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/checkpoint_queue_if.sv
// Checkpoint queue bus: allocate, resolve, mispredict and restore.
// Rename/branch unit is master, the checkpoint queue is slave.
interface checkpoint_queue_if #(
    parameter int NUM_CKPT = 4,
    parameter int TAG_W    = 5,
    parameter int NUM_PREG = 128
);
    localparam int ID_W  = $clog2(NUM_CKPT);
    localparam int CNT_W = ID_W + 1;

    logic                alloc_valid;
    logic [31:0]         alloc_pc;
    logic [TAG_W-1:0]    alloc_rob_tag;
    logic [NUM_PREG-1:0] alloc_rdy_table;
    logic                alloc_ready;
    logic [ID_W-1:0]     alloc_id;

    logic                resolve_valid;
    logic [ID_W-1:0]     resolve_id;
    logic                mispredict;
    logic [ID_W-1:0]     mispredict_id;

    logic                restore_valid;
    logic [31:0]         restore_pc;
    logic [TAG_W-1:0]    restore_rob_tag;
    logic [NUM_PREG-1:0] restore_rdy_table;
    logic [CNT_W-1:0]    count;

    modport master (
        output alloc_valid, alloc_pc, alloc_rob_tag,
        output alloc_rdy_table,
        output resolve_valid, resolve_id,
        output mispredict, mispredict_id,
        input  alloc_ready, alloc_id,
        input  restore_valid, restore_pc,
        input  restore_rob_tag, restore_rdy_table,
        input  count
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_rob_tag,
        input  alloc_rdy_table,
        input  resolve_valid, resolve_id,
        input  mispredict, mispredict_id,
        output alloc_ready, alloc_id,
        output restore_valid, restore_pc,
        output restore_rob_tag, restore_rdy_table,
        output count
    );
endinterface

// File: rtl/checkpoint_queue.sv
// Branch checkpoint queue: circular buffer of rename snapshots,
// in-order retirement of resolved branches, flush+restore on mispredict.
module checkpoint_queue #(
    parameter int NUM_CKPT = 4,
    parameter int TAG_W    = 5,
    parameter int NUM_PREG = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    checkpoint_queue_if.slave    bus
);
    localparam int ID_W  = $clog2(NUM_CKPT);
    localparam int CNT_W = ID_W + 1;

    logic [ID_W-1:0]     head;
    logic [ID_W-1:0]     tail;
    logic [CNT_W-1:0]    count_q;
    logic [NUM_CKPT-1:0] valid;
    logic [NUM_CKPT-1:0] resolved;

    logic [31:0]         pc_mem  [NUM_CKPT];
    logic [TAG_W-1:0]    tag_mem [NUM_CKPT];
    logic [NUM_PREG-1:0] rdy_mem [NUM_CKPT];

    logic                full;
    logic                acc;
    logic                ret;
    logic                res_ok;
    logic                mis_hit;
    logic [ID_W-1:0]     mis_off;
    logic [ID_W-1:0]     off;
    logic [NUM_CKPT-1:0] flush;
    logic [CNT_W-1:0]    n_flush;
    logic [NUM_CKPT-1:0] valid_n;
    logic [NUM_CKPT-1:0] resolved_n;

    assign full            = (count_q == CNT_W'(NUM_CKPT));
    assign bus.alloc_ready = !full;
    assign bus.alloc_id    = tail;
    assign bus.count       = count_q;

    // Age of each entry relative to head selects the flushed range;
    // valid entries are exactly head..tail-1, so this covers the full wrap case.
    always_comb begin
        mis_hit = bus.mispredict && valid[bus.mispredict_id];
        mis_off = bus.mispredict_id - head;
        off     = '0;
        flush   = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            off = ID_W'(i) - head;
            if (mis_hit && valid[i] && (off >= mis_off))
                flush[i] = 1'b1;
        end
        n_flush = mis_hit ? (count_q - {1'b0, mis_off}) : '0;
        acc     = bus.alloc_valid && !full && !bus.mispredict;
        ret     = valid[head] && resolved[head] && !flush[head];
        res_ok  = bus.resolve_valid && valid[bus.resolve_id]
                  && !flush[bus.resolve_id];
    end

    // Next valid/resolved vectors; retire applied last so it wins on head.
    always_comb begin
        valid_n    = valid & ~flush;
        resolved_n = resolved & ~flush;
        if (acc) begin
            valid_n[tail]    = 1'b1;
            resolved_n[tail] = 1'b0;
        end
        if (res_ok)
            resolved_n[bus.resolve_id] = 1'b1;
        if (ret) begin
            valid_n[head]    = 1'b0;
            resolved_n[head] = 1'b0;
        end
    end

    // Queue pointers, occupancy and per-entry status.
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
            valid    <= '0;
            resolved <= '0;
        end else begin
            valid    <= valid_n;
            resolved <= resolved_n;
            count_q  <= count_q + CNT_W'(acc) - CNT_W'(ret) - n_flush;
            if (ret)
                head <= head + 1'b1;
            if (mis_hit)
                tail <= bus.mispredict_id;
            else if (acc)
                tail <= tail + 1'b1;
        end
    end

    // Snapshot payload storage, written on accepted allocation.
    always_ff @(posedge clk) begin
        if (acc) begin
            pc_mem[tail]  <= bus.alloc_pc;
            tag_mem[tail] <= bus.alloc_rob_tag;
            rdy_mem[tail] <= bus.alloc_rdy_table;
        end
    end

    // One-cycle restore pulse; payload holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.restore_valid     <= 1'b0;
            bus.restore_pc        <= '0;
            bus.restore_rob_tag   <= '0;
            bus.restore_rdy_table <= '0;
        end else begin
            bus.restore_valid <= mis_hit;
            if (mis_hit) begin
                bus.restore_pc        <= pc_mem[bus.mispredict_id];
                bus.restore_rob_tag   <= tag_mem[bus.mispredict_id];
                bus.restore_rdy_table <= rdy_mem[bus.mispredict_id];
            end
        end
    end
endmodule

// File: tb/tb_checkpoint_queue.sv
// Directed bench for checkpoint_queue with a restore scoreboard.
// Expected restores are queued at mispredict time and popped on restore_valid.
module tb_checkpoint_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [31:0]  pc;
        logic [4:0]   tag;
        logic [127:0] rdy;
    } rst_t;

    rst_t exp_q[$];

    checkpoint_queue_if #(.NUM_CKPT(4), .TAG_W(5), .NUM_PREG(128)) bus ();

    checkpoint_queue #(.NUM_CKPT(4), .TAG_W(5), .NUM_PREG(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rdy_pat(input int k);
        logic [7:0] b;
        b = 8'hA4 + 8'(k);
        return {16{b}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alloc_valid     = 1'b0;
        bus.alloc_pc        = '0;
        bus.alloc_rob_tag   = '0;
        bus.alloc_rdy_table = '0;
        bus.resolve_valid   = 1'b0;
        bus.resolve_id      = '0;
        bus.mispredict      = 1'b0;
        bus.mispredict_id   = '0;
    endtask

    task automatic step();
        rst_t e;
        @(posedge clk);
        #1;
        if (bus.restore_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_restore", bus.restore_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("restore_pc", bus.restore_pc, e.pc);
                chk("restore_tag", bus.restore_rob_tag, e.tag);
                chk("restore_rdy", bus.restore_rdy_table, e.rdy);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic alloc(input int pc, input int tag, input logic [127:0] rdy);
        bus.alloc_valid     = 1'b1;
        bus.alloc_pc        = 32'(pc);
        bus.alloc_rob_tag   = 5'(tag);
        bus.alloc_rdy_table = rdy;
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) begin
            chk("fill_alloc_id", bus.alloc_id, k);
            alloc(32'h100 + 4 * k, k + 1, rdy_pat(k));
            step();
            idle();
        end
    endtask

    task automatic resolve(input int id);
        bus.resolve_valid = 1'b1;
        bus.resolve_id    = 2'(id);
    endtask

    task automatic mispred(input int id, input int pc, input int tag,
                           input logic [127:0] rdy, input bit expect_hit);
        rst_t e;
        bus.mispredict    = 1'b1;
        bus.mispredict_id = 2'(id);
        if (expect_hit) begin
            e.pc  = 32'(pc);
            e.tag = 5'(tag);
            e.rdy = rdy;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        idle();
        do_reset();
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.alloc_ready, 1);
        chk("rst_alloc_id", bus.alloc_id, 0);
        chk("rst_restore_valid", bus.restore_valid, 0);
        chk("rst_restore_pc", bus.restore_pc, 0);
        chk("rst_restore_rdy", bus.restore_rdy_table, 0);

        fill(4);
        chk("full_count", bus.count, 4);
        chk("full_ready", bus.alloc_ready, 0);
        alloc(32'h110, 5, '1);
        step();
        idle();
        chk("drop_count", bus.count, 4);
        chk("drop_tail", bus.alloc_id, 0);

        resolve(0);
        step();
        idle();
        chk("res_no_same_edge", bus.count, 4);
        step();
        chk("retire_count", bus.count, 3);
        chk("retire_ready", bus.alloc_ready, 1);
        chk("wrap_alloc_id", bus.alloc_id, 0);
        alloc(32'h200, 5, '0);
        step();
        idle();
        chk("wrap_count", bus.count, 4);
        chk("wrap_tail", bus.alloc_id, 1);

        resolve(3);
        step();
        resolve(2);
        step();
        resolve(1);
        step();
        idle();
        chk("ooo_hold", bus.count, 4);
        step();
        chk("ooo_ret1", bus.count, 3);
        step();
        chk("ooo_ret2", bus.count, 2);
        step();
        chk("ooo_ret3", bus.count, 1);
        chk("ooo_tail", bus.alloc_id, 1);
        resolve(0);
        step();
        idle();
        step();
        chk("ooo_empty", bus.count, 0);

        do_reset();
        fill(4);
        mispred(1, 32'h104, 2, rdy_pat(1), 1'b1);
        step();
        idle();
        chk("mp_restore_valid", bus.restore_valid, 1);
        chk("mp_count", bus.count, 1);
        chk("mp_tail", bus.alloc_id, 1);
        step();
        chk("mp_pulse_end", bus.restore_valid, 0);
        chk("mp_payload_hold", bus.restore_pc, 32'h104);
        resolve(2);
        step();
        idle();
        step();
        chk("mp_flushed_resolve", bus.count, 1);
        mispred(2, 0, 0, '0, 1'b0);
        alloc(32'h300, 7, '0);
        step();
        idle();
        chk("inv_mp_no_restore", bus.restore_valid, 0);
        chk("inv_mp_count", bus.count, 1);
        chk("inv_mp_tail", bus.alloc_id, 1);

        do_reset();
        fill(4);
        mispred(2, 32'h108, 3, rdy_pat(2), 1'b1);
        alloc(32'h400, 9, '1);
        resolve(3);
        step();
        idle();
        chk("sim_restore_valid", bus.restore_valid, 1);
        chk("sim_count", bus.count, 2);
        chk("sim_tail", bus.alloc_id, 2);
        mispred(1, 32'h104, 2, rdy_pat(1), 1'b1);
        resolve(0);
        alloc(32'h500, 10, '1);
        step();
        idle();
        chk("sim2_count", bus.count, 1);
        chk("sim2_tail", bus.alloc_id, 1);
        step();
        chk("sim2_older_resolve", bus.count, 0);

        do_reset();
        fill(4);
        resolve(0);
        step();
        idle();
        chk("prio_hold", bus.count, 4);
        mispred(0, 32'h100, 1, rdy_pat(0), 1'b1);
        step();
        idle();
        chk("prio_full_flush", bus.count, 0);
        chk("prio_tail", bus.alloc_id, 0);
        chk("prio_ready", bus.alloc_ready, 1);

        do_reset();
        fill(3);
        mispred(1, 0, 0, '0, 1'b0);
        alloc(32'h600, 11, '1);
        resolve(0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        chk("rmid_count", bus.count, 0);
        chk("rmid_restore", bus.restore_valid, 0);
        chk("rmid_tail", bus.alloc_id, 0);
        chk("rmid_ready", bus.alloc_ready, 1);
        step();
        chk("rmid_no_pulse", bus.restore_valid, 0);
        chk("rmid_count2", bus.count, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
